// File: rtl/phase_a_sequencer.sv
// Drives a phase_a datapath for a requested number of passes, feeding each result
// back as the next operand, and returns the final operand on a valid/ready port.
module phase_a_sequencer #(
    parameter int Size    = 3072,
    parameter int radix   = 54,
    parameter int ITER_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Size-1:0]     in_a,
    input  logic [ITER_W-1:0]   in_iters,
    input  logic [Size-1:0]     in_m,
    input  logic [Size+1:0]     in_m_n,
    input  logic [radix+1:0]    in_m_prime,
    output logic                pa_en,
    output logic [Size-1:0]     pa_a,
    output logic [Size-1:0]     pa_m,
    output logic [Size+1:0]     pa_m_n,
    output logic [radix+1:0]    pa_m_prime,
    input  logic [Size-1:0]     pa_new_a,
    input  logic                pa_en_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Size-1:0]     out_a,
    output logic                out_err,
    output logic                busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Leaving WAIT when the counter holds TIMEOUT-2 means it reaches TIMEOUT-1 on
    // the exit edge, so DONE starts exactly TIMEOUT cycles after the LAUNCH cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [Size-1:0]     work_a;
    logic [Size-1:0]     m_q;
    logic [Size+1:0]     m_n_q;
    logic [radix+1:0]    m_prime_q;
    logic [ITER_W-1:0]   iter_left;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                err_q;
    logic                accept;
    logic                capture;
    logic                timeout;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (in_iters != '0) ? LAUNCH : DONE;
                end
            end
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                // A done strobe wins over a timeout landing in the same cycle.
                if (pa_en_out) begin
                    capture   = 1'b1;
                    state_nxt = (iter_left == ITER_W'(1)) ? DONE : LAUNCH;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work_a    <= '0;
            m_q       <= '0;
            m_n_q     <= '0;
            m_prime_q <= '0;
            iter_left <= '0;
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work_a    <= in_a;
                m_q       <= in_m;
                m_n_q     <= in_m_n;
                m_prime_q <= in_m_prime;
                iter_left <= in_iters;
                err_q     <= 1'b0;
            end
            if (state == LAUNCH) tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (capture) begin
                work_a    <= pa_new_a;
                iter_left <= iter_left - ITER_W'(1);
            end
            if (timeout) err_q <= 1'b1;
        end
    end

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign pa_en      = (state == LAUNCH);
    assign out_valid  = (state == DONE);
    assign pa_a       = work_a;
    assign pa_m       = m_q;
    assign pa_m_n     = m_n_q;
    assign pa_m_prime = m_prime_q;
    assign out_a      = work_a;
    assign out_err    = err_q;

endmodule

// File: tb/tb_phase_a_sequencer.sv
// Scoreboard bench for phase_a_sequencer driven by a behavioural phase_a stub
// that returns a+1 after a programmable latency.
module tb_phase_a_sequencer;

    localparam int SZ = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SZ-1:0]   in_a;
    logic [7:0]      in_iters;
    logic [SZ-1:0]   in_m;
    logic [SZ+1:0]   in_m_n;
    logic [55:0]     in_m_prime;
    logic            pa_en;
    logic [SZ-1:0]   pa_a;
    logic [SZ-1:0]   pa_m;
    logic [SZ+1:0]   pa_m_n;
    logic [55:0]     pa_m_prime;
    logic [SZ-1:0]   pa_new_a;
    logic            pa_en_out;
    logic            out_valid;
    logic            out_ready;
    logic [SZ-1:0]   out_a;
    logic            out_err;
    logic            busy;

    phase_a_sequencer #(.Size(SZ), .radix(54), .ITER_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_iters(in_iters),
        .in_m(in_m), .in_m_n(in_m_n), .in_m_prime(in_m_prime),
        .pa_en(pa_en), .pa_a(pa_a), .pa_m(pa_m), .pa_m_n(pa_m_n), .pa_m_prime(pa_m_prime),
        .pa_new_a(pa_new_a), .pa_en_out(pa_en_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SZ-1:0] a;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        cmp_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Stub phase_a: responds stub_lat cycles after a launch with a+1.
    int   stub_lat = 20;
    bit   stub_on  = 1'b0;
    bit   stale_tog = 1'b0;

    initial begin : stub
        int            busy_cnt;
        logic [SZ-1:0] a_l;
        bit            seen_tog;
        busy_cnt  = 0;
        a_l       = '0;
        seen_tog  = 1'b0;
        pa_en_out = 1'b0;
        pa_new_a  = '0;
        forever begin
            @(negedge clk);
            pa_en_out = 1'b0;
            if (stale_tog != seen_tog) begin
                seen_tog  = stale_tog;
                pa_new_a  = 64'hDEAD;
                pa_en_out = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    pa_new_a  = a_l + 64'd1;
                    pa_en_out = 1'b1;
                end
            end else if (pa_en && stub_on) begin
                a_l      = pa_a;
                busy_cnt = stub_lat;
            end
        end
    end

    // Launch pulse observer: count, width and spacing of pa_en pulses.
    int pulses = 0;
    int last_rise = -1;
    int min_gap = 1000000;
    bit wide_pulse = 1'b0;

    initial begin : pulse_mon
        bit prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (pa_en) begin
                pulses++;
                if (prev_en) wide_pulse = 1'b1;
                else begin
                    if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
                    last_rise = cyc;
                end
            end
            prev_en = pa_en;
        end
    end

    // Result monitor: pops the scoreboard on each result handshake.
    initial begin : result_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    cmp_cnt++;
                    fail_cnt++;
                    $display("FAIL unexpected_result: got out_a=%0h err=%0b, expected none", out_a, out_err);
                end else begin
                    e = exp_q.pop_front();
                    check("out_a", 128'(out_a), 128'(e.a));
                    check("out_err", 128'(out_err), 128'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic [SZ-1:0] a, input logic [7:0] iters,
                         input bit push, input logic [SZ-1:0] ea, input logic ee);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("issue_wait_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_iters = iters;
        if (push) exp_q.push_back('{a: ea, err: ee});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({name, "_drain_timeout"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p0;
        int n;
        bit stable;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_iters   = '0;
        in_m       = '0;
        in_m_n     = '0;
        in_m_prime = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_pa_en", 128'(pa_en), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_err", 128'(out_err), 128'(0));
        check("rst_out_a", 128'(out_a), 128'(0));
        check("rst_pa_m", 128'(pa_m), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: three passes of a+1 with latency 20, inputs disturbed while busy.
        stub_on = 1'b1; stub_lat = 20;
        in_m = 64'h5555_AAAA_1234_5678; in_m_n = 66'h2_0F0F_0F0F_0F0F_0F0F; in_m_prime = 56'h12_3456_789A_BCDE;
        pulses = 0; last_rise = -1; min_gap = 1000000; wide_pulse = 1'b0;
        issue(64'd5, 8'd3, 1'b1, 64'd8, 1'b0);
        repeat (5) @(negedge clk);
        in_valid = 1'b1; in_a = 64'hFFFF; in_iters = 8'd0;
        in_m = 64'h9999; in_m_n = '0; in_m_prime = '0;
        @(negedge clk);
        check("t1_busy_in_ready", 128'(in_ready), 128'(0));
        check("t1_pa_a_hold", 128'(pa_a), 128'(5));
        check("t1_pa_m_hold", 128'(pa_m), 128'(64'h5555_AAAA_1234_5678));
        check("t1_pa_m_n_hold", 128'(pa_m_n), 128'(66'h2_0F0F_0F0F_0F0F_0F0F));
        check("t1_pa_m_prime_hold", 128'(pa_m_prime), 128'(56'h12_3456_789A_BCDE));
        in_valid = 1'b0;
        drain("t1", 500);
        check("t1_pulses", 128'(pulses), 128'(3));
        check("t1_min_gap_ge_21", 128'(min_gap >= 21), 128'(1));
        check("t1_single_cycle_pa_en", 128'(wide_pulse), 128'(0));

        // T2: zero iterations returns the operand one cycle after accept.
        p0 = pulses;
        issue(64'h1234, 8'd0, 1'b1, 64'h1234, 1'b0);
        @(negedge clk);
        check("t2_out_valid_latency", 128'(out_valid), 128'(1));
        drain("t2", 50);
        check("t2_no_pulse", 128'(pulses - p0), 128'(0));

        // T3: stub silent -> timeout 64 cycles after launch, error flagged.
        stub_on = 1'b0;
        p0 = pulses;
        issue(64'hABC, 8'd2, 1'b1, 64'hABC, 1'b1);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t3_out_valid_seen", 128'(out_valid), 128'(1));
        check("t3_timeout_cycles", 128'(cyc - last_rise), 128'(64));
        drain("t3", 50);
        check("t3_one_pulse", 128'(pulses - p0), 128'(1));

        // T4: result held while out_ready is low; err cleared by new request.
        stub_on = 1'b1; stub_lat = 20;
        out_ready = 1'b0;
        issue(64'h10, 8'd1, 1'b1, 64'h11, 1'b0);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(out_valid && out_a == 64'h11 && !out_err && !in_ready)) stable = 1'b0;
            @(negedge clk);
        end
        check("t4_hold_stable", 128'(stable), 128'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_in_ready_after_hs", 128'(in_ready), 128'(1));
        check("t4_out_valid_after_hs", 128'(out_valid), 128'(0));
        drain("t4", 50);

        // Maximum iteration count with a short latency.
        stub_lat = 2;
        issue(64'h100, 8'd255, 1'b1, 64'h1FF, 1'b0);
        drain("max_iters", 3000);

        // T5: reset during WAIT, then a stale done strobe.
        stub_on = 1'b0;
        issue(64'h77, 8'd2, 1'b0, '0, 1'b0);
        repeat (5) @(negedge clk);
        check("t5_busy_before_rst", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_pa_en", 128'(pa_en), 128'(0));
        check("t5_rst_busy", 128'(busy), 128'(0));
        check("t5_rst_out_valid", 128'(out_valid), 128'(0));
        check("t5_rst_out_a", 128'(out_a), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        stale_tog = ~stale_tog;
        repeat (4) @(negedge clk);
        check("t5_stale_busy", 128'(busy), 128'(0));
        check("t5_stale_out_valid", 128'(out_valid), 128'(0));
        check("t5_stale_out_a", 128'(out_a), 128'(0));
        check("t5_scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
